// File: rtl/tri_vertex_ctrl.sv
// tri_vertex_ctrl
// Vertex configuration controller for the point-in-triangle pixel datapath.
// A requester fills a shadow bank of six coordinates through a valid/ready
// port and then issues a commit. The shadow bank is copied to the active
// bank only at a frame boundary, so the triangle never tears mid-frame.
// The active bank is registered and drives the datapath vertex inputs.
//
// Optional feature macro: TRI_AUTO_MOVE_EN
//   When defined, the active X coordinates scroll by one pixel per frame and
//   bounce off the visible edges. When undefined, the active bank changes
//   only on a commit apply or on RESET.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | accepting writes; commit transfer arms the controller
// ARMED | commit pending, writes stalled, waiting for frame_start
// APPLY | single cycle: active <= shadow, commit_count++

module tri_vertex_ctrl #(
  parameter int COORD_W = 12,
  parameter int X_LIMIT = 1300,
  parameter int Y_LIMIT = 505,
  parameter int P1X_RST = 200,
  parameter int P1Y_RST = 100,
  parameter int P2X_RST = 500,
  parameter int P2Y_RST = 300,
  parameter int P3X_RST = 500,
  parameter int P3Y_RST = 100
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               frame_start,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [2:0]         wr_addr,
  input  logic [COORD_W-1:0] wr_data,
  output logic [COORD_W-1:0] p1x,
  output logic [COORD_W-1:0] p1y,
  output logic [COORD_W-1:0] p2x,
  output logic [COORD_W-1:0] p2y,
  output logic [COORD_W-1:0] p3x,
  output logic [COORD_W-1:0] p3y,
  output logic               pending,
  output logic [7:0]         commit_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  localparam logic [2:0] ADDR_COMMIT = 3'd6;

  state_t state, state_nxt;

  logic [COORD_W-1:0] shadow [6];
  logic [COORD_W-1:0] active [6];

  logic wr_fire;
  logic apply_en;
  logic idle_frame;

  // Bank index order is P1X,P1Y,P2X,P2Y,P3X,P3Y; even indices are X fields.
  function automatic logic [COORD_W-1:0] rst_val(input int idx);
    case (idx)
      0:       rst_val = COORD_W'(P1X_RST);
      1:       rst_val = COORD_W'(P1Y_RST);
      2:       rst_val = COORD_W'(P2X_RST);
      3:       rst_val = COORD_W'(P2Y_RST);
      4:       rst_val = COORD_W'(P3X_RST);
      5:       rst_val = COORD_W'(P3Y_RST);
      default: rst_val = '0;
    endcase
  endfunction

  // Saturate a coordinate to the visible area; X on even addresses, Y on odd.
  function automatic logic [COORD_W-1:0] clamp(input logic [2:0] addr,
                                               input logic [COORD_W-1:0] d);
    clamp = d;
    if (addr[0] == 1'b0) begin
      if (int'(d) >= X_LIMIT) clamp = COORD_W'(X_LIMIT - 1);
    end else begin
      if (int'(d) >= Y_LIMIT) clamp = COORD_W'(Y_LIMIT - 1);
    end
  endfunction

  // Writes are accepted only in IDLE; ready depends on state alone.
  assign wr_fire    = wr_valid && (state == ST_IDLE);
  assign idle_frame = frame_start && (state == ST_IDLE);

  // State register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    pending   = 1'b0;
    apply_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        wr_ready = 1'b1;
        // A frame_start in the same cycle as the commit is not consumed here;
        // ARMED waits for the next pulse.
        if (wr_valid && (wr_addr == ADDR_COMMIT)) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        pending = 1'b1;
        if (frame_start) state_nxt = ST_APPLY;
      end
      ST_APPLY: begin
        pending   = 1'b1;
        apply_en  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shadow bank: clamped coordinate writes; commit and no-op leave it alone.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 6; i++) shadow[i] <= rst_val(i);
    end else if (wr_fire) begin
      for (int i = 0; i < 6; i++) begin
        if (wr_addr == 3'(i)) shadow[i] <= clamp(wr_addr, wr_data);
      end
    end
  end

`ifdef TRI_AUTO_MOVE_EN
  // dir = 1 means +1 pixel per frame, dir = 0 means -1.
  logic               dir;
  logic [COORD_W-1:0] x_max;
  logic [COORD_W-1:0] x_min;
  logic               move_hit;

  // Edge detection for the bounce: stepping would leave the visible width.
  always_comb begin
    x_max    = active[0];
    x_min    = active[0];
    move_hit = 1'b0;
    if (active[2] > x_max) x_max = active[2];
    if (active[4] > x_max) x_max = active[4];
    if (active[2] < x_min) x_min = active[2];
    if (active[4] < x_min) x_min = active[4];
    if (dir) move_hit = (int'(x_max) + 1) >= X_LIMIT;
    else     move_hit = (x_min == '0);
  end

  // Direction register: flips on a blocked move, forced forward on apply.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET)                       dir <= 1'b1;
    else if (apply_en)               dir <= 1'b1;
    else if (idle_frame && move_hit) dir <= ~dir;
  end
`endif

  // Active bank: loaded from shadow on apply (and scrolled when enabled).
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 6; i++) active[i] <= rst_val(i);
    end else if (apply_en) begin
      for (int i = 0; i < 6; i++) active[i] <= shadow[i];
    end
`ifdef TRI_AUTO_MOVE_EN
    else if (idle_frame && !move_hit) begin
      for (int i = 0; i < 6; i += 2) begin
        if (dir) active[i] <= active[i] + COORD_W'(1);
        else     active[i] <= active[i] - COORD_W'(1);
      end
    end
`else
    else if (idle_frame) begin
      for (int i = 0; i < 6; i++) active[i] <= active[i];
    end
`endif
  end

  // Applied-commit counter, wraps naturally at 8 bits.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET)         commit_count <= 8'd0;
    else if (apply_en) commit_count <= commit_count + 8'd1;
  end

  assign p1x = active[0];
  assign p1y = active[1];
  assign p2x = active[2];
  assign p2y = active[3];
  assign p3x = active[4];
  assign p3y = active[5];

endmodule

// File: doc/tri_vertex_ctrl.md
Name: tri_vertex_ctrl

Overview:
Configuration controller for the point-in-triangle pixel datapath of the VGA block. A requester writes six vertex coordinates into a shadow bank through a valid/ready port, then issues a commit. The controller copies the shadow bank to the active bank only at a frame boundary, so the triangle never tears mid-frame. The active bank drives the datapath vertex inputs directly.

Parameters:
COORD_W, 12, coordinate width in bits
X_LIMIT, 1300, exclusive upper bound for X coordinates (visible width)
Y_LIMIT, 505, exclusive upper bound for Y coordinates (visible height)
P1X_RST, 200, reset value of P1X; likewise P1Y_RST=100, P2X_RST=500, P2Y_RST=300, P3X_RST=500, P3Y_RST=100

Ports:
CLOCK_50  in  1  system clock
RESET  in  1  reset, asynchronous, active-high
frame_start  in  1  one-cycle pulse at h_count==0 and v_count==0
wr_valid  in  1  write request
wr_ready  out  1  controller can accept a write
wr_addr  in  3  0..5 = P1X,P1Y,P2X,P2Y,P3X,P3Y; 6 = commit; 7 = no-op
wr_data  in  COORD_W  write data (ignored for addr 6 and 7)
p1x,p1y,p2x,p2y,p3x,p3y  out  COORD_W each  active vertex bank to the datapath
pending  out  1  commit armed, waiting for a frame boundary
commit_count  out  8  number of applied commits, wraps at 255->0

Behaviour:
- Clock and reset: one clock, CLOCK_50. RESET is asynchronous and active-high.
- Reset values:
  - Active and shadow banks take the *_RST parameter values.
  - State = IDLE, wr_ready=1, pending=0, commit_count=0.
- Write transfer occurs on a rising edge with wr_valid&&wr_ready. Address decode:
  - addr 0..5: shadow[addr] <= clamp(wr_data).
  - addr 6: state goes to ARMED.
  - addr 7: accepted and discarded.
- Clamp rules:
  - X field: wr_data >= X_LIMIT -> X_LIMIT-1.
  - Y field: wr_data >= Y_LIMIT -> Y_LIMIT-1.
  - Values are unsigned.
- Changing the shadow bank never affects the outputs until a commit is applied.
- FSM:
  - IDLE: wr_ready=1, pending=0. A commit transfer goes to ARMED.
  - ARMED: wr_ready=0, pending=1. frame_start goes to APPLY; otherwise stay in ARMED.
  - APPLY (exactly 1 cycle): wr_ready=0, pending=1. Active <= shadow (all six at once), commit_count++, then go to IDLE.
- Latency: the outputs change on the edge after the edge that samples frame_start in ARMED, i.e. 2 edges after the pulse. This is still inside blanking.
- Simultaneous events:
  - A commit accepted in the same cycle as frame_start does not use that pulse. Go to ARMED and wait for the next frame_start.
  - frame_start during APPLY is ignored.
- Back-to-back: wr_valid may stay high. Writes stall (wr_ready=0) while ARMED or APPLY and resume in IDLE.
- Degenerate triangles (collinear or coincident vertices) are passed through unchanged. Detecting them is the datapath's concern.
- RESET mid-operation: an armed commit is discarded and both banks return to the *_RST values immediately.
- Outputs are registered only. There is no combinational path from wr_* to p*.

Optional Feature:
TRI_AUTO_MOVE_EN
- When defined:
  - Adds a 1-bit direction register dir, reset to +1.
  - On each frame_start seen in IDLE, all three active X coordinates move by dir (+1/-1).
  - If max(Xi)+1 would reach X_LIMIT (dir=+1), or min(Xi)-1 would go below 0 (dir=-1), dir flips and no move occurs that frame.
  - APPLY sets dir=+1.
  - Y coordinates and the shadow bank are untouched.
- When undefined: the active bank changes only on APPLY or RESET. There is no dir register.

Test Plan:
- Reset: assert RESET asynchronously mid-cycle -> p1x..p3y = 200,100,500,300,500,100; wr_ready=1; pending=0; commit_count=0.
- Write/commit: write addr0..5 = 10,20,30,40,50,60, then addr6 -> outputs unchanged and pending=1, wr_ready=0 until frame_start; 2 edges after the pulse outputs = 10,20,30,40,50,60, commit_count=1, wr_ready=1.
- Clamp: write P2X=4000 and P3Y=600, then commit -> p2x=1299, p3y=504.
- Simultaneous: commit accepted in the frame_start cycle -> no apply on that pulse; apply on the next pulse. Write attempted while ARMED -> wr_ready=0, shadow unchanged.
- Reset mid-ARMED: RESET while pending=1 -> pending=0; outputs at reset values; the later frame_start causes no apply.
- TRI_AUTO_MOVE_EN: commit X = 1297,1290,1280 -> frame1 X+1 (max 1298), frame2 X+1 (max 1299), frame3 no move and dir=-1, frame4 X-1.
